// File: rtl/ucode_loader.sv
// ucode_loader: writer side of the microprogram control store.
// Assembles a framed byte stream (SYNC, addr, count, count*4 data bytes,
// checksum) into microinstruction words, writes each word to the control
// store as soon as it is complete, and holds the CPU while a frame loads.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   in_data   in   byte from the byte source
//   in_valid  in   in_data valid this cycle
//   in_ready  out  byte accepted when in_valid && in_ready (low only in reset)
//   we        out  control-store write enable, one cycle per word
//   waddr     out  control-store write address
//   wdata     out  control-store write data
//   cpu_hold  out  high while a frame is loading
//   done      out  one-cycle pulse, frame complete with good checksum
//   err       out  one-cycle pulse, frame aborted
//   err_code  out  01 checksum mismatch, 10 timeout; cleared by next SYNC
module ucode_loader #(
  parameter int          WORD_WIDTH     = 29,
  parameter int          ADDR_WIDTH     = 8,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [WORD_WIDTH-1:0] wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_COUNT = 3'd2,
    S_DATA  = 3'd3,
    S_CHECK = 3'd4
  } state_t;

  // Timeout fires on the idle cycle that would take the timer to TIMEOUT_CYCLES.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              cnt_q;      // words left; 0 encodes 256
  logic [1:0]              byte_idx_q;
  logic [23:0]             word_buf_q; // bytes 0..2 of the word in progress
  logic [7:0]              sum_q;
  logic [15:0]             timer_q;
  logic                    in_ready_q;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   waddr_q;
  logic [WORD_WIDTH-1:0]   wdata_q;
  logic                    cpu_hold_q;
  logic                    done_q;
  logic                    err_q;
  logic [1:0]              err_code_q;

  logic                    accept_s;
  logic                    timeout_s;

  // Byte handshake and inter-byte timeout detection.
  always_comb begin
    accept_s  = 1'b0;
    timeout_s = 1'b0;
    accept_s  = in_valid && in_ready_q;
    if ((state_q != S_IDLE) && !accept_s && (timer_q == TMO_LAST)) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Frame FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= 8'd0;
      byte_idx_q <= 2'd0;
      word_buf_q <= 24'd0;
      sum_q      <= 8'd0;
      timer_q    <= 16'd0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      in_ready_q <= 1'b1;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;

      if (state_q != S_IDLE) begin
        timer_q <= accept_s ? 16'd0 : timer_q + 16'd1;
      end

      if (timeout_s) begin
        // Abort: the partially assembled word is simply dropped.
        state_q    <= S_IDLE;
        cpu_hold_q <= 1'b0;
        err_q      <= 1'b1;
        err_code_q <= 2'b10;
        timer_q    <= 16'd0;
      end else if (accept_s) begin
        if (state_q != S_IDLE) begin
          sum_q <= sum_q + in_data;
        end
        case (state_q)
          S_IDLE: begin
            if (in_data == SYNC_BYTE) begin
              state_q    <= S_ADDR;
              cpu_hold_q <= 1'b1;
              err_code_q <= 2'b00;
              sum_q      <= 8'd0;
              timer_q    <= 16'd0;
              byte_idx_q <= 2'd0;
            end
          end
          S_ADDR: begin
            addr_q  <= ADDR_WIDTH'(in_data);
            state_q <= S_COUNT;
          end
          S_COUNT: begin
            cnt_q      <= in_data;
            byte_idx_q <= 2'd0;
            state_q    <= S_DATA;
          end
          S_DATA: begin
            word_buf_q <= {in_data, word_buf_q[23:8]};
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              // Fourth byte: upper bits beyond the word width are dropped.
              we_q    <= 1'b1;
              waddr_q <= addr_q;
              wdata_q <= {in_data[WORD_WIDTH-25:0], word_buf_q};
              addr_q  <= addr_q + 1'b1;
              cnt_q   <= cnt_q - 8'd1;
              if (cnt_q == 8'd1) begin
                state_q <= S_CHECK;
              end
            end
          end
          S_CHECK: begin
            state_q    <= S_IDLE;
            cpu_hold_q <= 1'b0;
            if (8'(sum_q + in_data) == 8'h00) begin
              done_q <= 1'b1;
            end else begin
              err_q      <= 1'b1;
              err_code_q <= 2'b01;
            end
          end
          default: begin
            state_q    <= S_IDLE;
            cpu_hold_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign in_ready = in_ready_q;
  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_ucode_loader.sv
// Scoreboard bench for ucode_loader: frames are generated randomly, their
// expected control-store writes and end-of-frame pulses are derived from the
// frame rules and queued, and a monitor pops/compares on every DUT output.
module tb_ucode_loader;
  localparam int WW  = 29;
  localparam int AW  = 8;
  localparam int TMO = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [WW-1:0] wdata;
  logic          cpu_hold;
  logic          done;
  logic          err;
  logic [1:0]    err_code;

  always #5 clk = ~clk;

  ucode_loader #(
    .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .we(we), .waddr(waddr), .wdata(wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err), .err_code(err_code)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [WW-1:0] d;
  } wr_t;

  wr_t         wq[$];   // expected writes
  logic [1:0]  evq[$];  // expected end pulses: 00 done, 01 bad checksum, 10 timeout
  logic [31:0] wbuf[$]; // optional fixed words for the next frame
  int          total = 0;
  int          bad   = 0;
  wr_t         mon_w;
  logic [1:0]  mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write or end pulse must match the head of its queue.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (we) begin
        if (wq.size() == 0) begin
          chk("unexpected_we", we, 1'b0);
        end else begin
          mon_w = wq.pop_front();
          chk("waddr", waddr, mon_w.a);
          chk("wdata", wdata, mon_w.d);
          chk("hold_during_write", cpu_hold, 1'b1);
        end
      end
      if (done || err) begin
        if (evq.size() == 0) begin
          chk("unexpected_pulse", {done, err}, 2'b00);
        end else begin
          mon_e = evq.pop_front();
          chk("done", done, mon_e == 2'b00);
          chk("err", err, mon_e != 2'b00);
          chk("err_code", err_code, mon_e);
          chk("hold_falls_with_pulse", cpu_hold, 1'b0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Bounded wait for every queued expectation to be consumed.
  task automatic drain(input string name);
    int k = 0;
    while ((wq.size() != 0 || evq.size() != 0) && k < 40) begin
      tick();
      k++;
    end
    total++;
    if (wq.size() != 0 || evq.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d writes and %0d pulses never appeared", name, wq.size(), evq.size());
      wq.delete();
      evq.delete();
    end
  endtask

  // Build one frame from the rules, queue its expected effects, send it.
  task automatic frame(input logic [7:0] a, input logic [7:0] c, input logic [7:0] corrupt,
                       input int max_gap, input int gap_at, input int gap_len);
    int          n;
    logic [7:0]  s;
    logic [31:0] w;
    logic [7:0]  fb[$];
    wr_t         e;
    n = (c == 8'd0) ? 256 : int'(c);
    s = a + c;
    fb.push_back(a);
    fb.push_back(c);
    for (int i = 0; i < n; i++) begin
      w = (wbuf.size() != 0) ? wbuf.pop_front() : $urandom;
      e.a = AW'((int'(a) + i) % 256);
      e.d = w[WW-1:0];
      wq.push_back(e);
      for (int j = 0; j < 4; j++) begin
        fb.push_back(w[8*j +: 8]);
        s = s + w[8*j +: 8];
      end
    end
    fb.push_back(8'(8'd0 - s) ^ corrupt);
    evq.push_back((corrupt == 8'd0) ? 2'b00 : 2'b01);
    chk("hold_before_sync", cpu_hold, 1'b0);
    send(8'hA5);
    chk("hold_after_sync", cpu_hold, 1'b1);
    for (int k = 0; k < fb.size(); k++) begin
      if (k == gap_at) idle(gap_len);
      else if (max_gap > 0) idle($urandom_range(max_gap, 0));
      send(fb[k]);
    end
    drain("frame_end");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_we", we, 1'b0);
    chk("rst_waddr", waddr, '0);
    chk("rst_wdata", wdata, '0);
    chk("rst_hold", cpu_hold, 1'b0);
    chk("rst_done_err", {done, err}, 2'b00);
    chk("rst_err_code", err_code, 2'b00);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", in_ready, 1'b1);

    // Nominal frame; checksum derived from the sum rule.
    wbuf.push_back(32'h1ABCDEF0);
    wbuf.push_back(32'h00000001);
    frame(8'h10, 8'h02, 8'h00, 0, -1, 0);
    chk("err_code_after_done", err_code, 2'b00);

    // Same frame, corrupted checksum: writes still happen, err 01.
    wbuf.push_back(32'h1ABCDEF0);
    wbuf.push_back(32'h00000001);
    frame(8'h10, 8'h02, 8'h5C, 0, -1, 0);
    chk("err_code_holds_01", err_code, 2'b01);

    // Address wrap, and SYNC-valued bytes inside the data.
    wbuf.push_back(32'hA5A5A5A5);
    frame(8'hFF, 8'h02, 8'h00, 0, -1, 0);

    // Count 0 means 256 words; next write lands back at the start address.
    frame(8'h37, 8'h00, 8'h00, 0, -1, 0);
    frame(8'h37, 8'h01, 8'h00, 0, -1, 0);

    // Timeout after two data bytes: err 10 and no write.
    send(8'hA5);
    send(8'h40);
    send(8'h03);
    send(8'h11);
    send(8'h22);
    idle(TMO - 1);
    evq.push_back(2'b10);
    idle(1);
    drain("timeout");
    chk("err_code_holds_10", err_code, 2'b10);
    chk("hold_after_timeout", cpu_hold, 1'b0);

    // A gap one short of the timeout must not abort; frame completes.
    frame(8'h20, 8'h01, 8'h00, 0, 3, TMO - 1);

    // Random frames with small gaps, random checksum faults and IDLE garbage.
    for (int r = 0; r < 8; r++) begin
      for (int g = $urandom_range(2, 0); g > 0; g--) begin
        send(8'($urandom_range(8'hA4, 0)));
      end
      frame(8'($urandom), 8'($urandom_range(4, 1)),
            ($urandom_range(2, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00,
            3, -1, 0);
    end

    // Reset mid-DATA: one word written, partial word dropped, no pulses.
    wbuf.push_back(32'h0BADF00D);
    send(8'hA5);
    send(8'h50);
    send(8'h02);
    mon_w.a = 8'h50;
    mon_w.d = WW'(32'h0BADF00D);
    wq.push_back(mon_w);
    send(8'h0D);
    send(8'hF0);
    send(8'hAD);
    send(8'h0B);
    send(8'h77);
    rst = 1'b1;
    tick();
    chk("midrst_hold", cpu_hold, 1'b0);
    chk("midrst_ready", in_ready, 1'b0);
    chk("midrst_pulses", {we, done, err}, 3'b000);
    rst = 1'b0;
    tick();
    chk("midrst_ready_back", in_ready, 1'b1);
    send(8'h00);
    chk("garbage_hold_00", cpu_hold, 1'b0);
    send(8'hFF);
    chk("garbage_hold_FF", cpu_hold, 1'b0);
    send(8'hA4);
    chk("garbage_hold_A4", cpu_hold, 1'b0);
    idle(3);
    chk("garbage_err_code", err_code, 2'b00);
    drain("after_reset");

    // Clean frame after reset still works.
    frame(8'h80, 8'h03, 8'h00, 1, -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
